// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_pkg
// Purpose  : Shared constants and types for the display scan-out path.
//            Default raster timing, derived totals, pixel/address widths,
//            the line FSM state type and the RGB pixel struct.
// Revision : 1.0 - initial release
// ============================================================================
package display_pkg;

    // Default raster timing (pixels / lines)
    localparam int DEF_H_ACTIVE = 100;
    localparam int DEF_H_FP     = 4;
    localparam int DEF_H_SYNC   = 8;
    localparam int DEF_H_BP     = 8;
    localparam int DEF_V_ACTIVE = 100;
    localparam int DEF_V_FP     = 2;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 4;

    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int PIX_W  = 8;
    localparam int ADDR_W = 7;

    typedef enum logic [1:0] {
        ST_BLANK    = 2'd0,
        ST_SCAN     = 2'd1,
        ST_UNDERRUN = 2'd2,
        ST_RELEASE  = 2'd3
    } line_state_t;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_t;

endpackage
`default_nettype wire

// File: rtl/display_scanout_if.sv
`default_nettype none
// ============================================================================
// Module   : display_scanout_if
// Purpose  : Line-buffer read bundle between the scan-out engine (master)
//            and the two ping-pong line buffers (slave).
//   buf_ready[1:0]    buffer -> master  line fully written and valid
//   buf_release[1:0]  master -> buffer  one-cycle "line consumed" pulse
//   RE0/Addr0         master -> buffer0 read enable / address
//   *_pix0            buffer0 -> master read data, 1 cycle after RE0
//   RE1/Addr1, *_pix1 same for buffer 1
// Revision : 1.0 - initial release
// ============================================================================
interface display_scanout_if;

    logic [1:0]                     buf_ready;
    logic [1:0]                     buf_release;

    logic                           RE0;
    logic [display_pkg::ADDR_W-1:0] Addr0;
    logic [display_pkg::PIX_W-1:0]  red_pix0;
    logic [display_pkg::PIX_W-1:0]  green_pix0;
    logic [display_pkg::PIX_W-1:0]  blue_pix0;

    logic                           RE1;
    logic [display_pkg::ADDR_W-1:0] Addr1;
    logic [display_pkg::PIX_W-1:0]  red_pix1;
    logic [display_pkg::PIX_W-1:0]  green_pix1;
    logic [display_pkg::PIX_W-1:0]  blue_pix1;

    modport master (
        input  buf_ready,
        input  red_pix0, green_pix0, blue_pix0,
        input  red_pix1, green_pix1, blue_pix1,
        output buf_release,
        output RE0, Addr0,
        output RE1, Addr1
    );

    modport slave (
        output buf_ready,
        output red_pix0, green_pix0, blue_pix0,
        output red_pix1, green_pix1, blue_pix1,
        input  buf_release,
        input  RE0, Addr0,
        input  RE1, Addr1
    );

endinterface
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_gen
// Purpose  : Horizontal/vertical raster counters and raw (unregistered)
//            timing decodes.
//   clock, reset   single clock, synchronous active-high reset
//   h              horizontal counter, 0..H_TOTAL-1
//   active         h < H_ACTIVE and v < V_ACTIVE
//   hs_raw         h inside the hsync window
//   vs_raw         v inside the vsync window
//   line_start     h == 0 on an active line
// Revision : 1.0 - initial release
// ============================================================================
module video_timing_gen
    import display_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int H_W      = $clog2(DEF_H_TOTAL)
)(
    input  logic           clock,
    input  logic           reset,
    output logic [H_W-1:0] h,
    output logic           active,
    output logic           hs_raw,
    output logic           vs_raw,
    output logic           line_start
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_V_W     = $clog2(c_V_TOTAL);

    logic [H_W-1:0]   r_h;
    logic [c_V_W-1:0] r_v;
    logic             w_v_active;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == H_W'(c_H_TOTAL - 1)) begin
            r_h <= '0;
            r_v <= (r_v == c_V_W'(c_V_TOTAL - 1)) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    assign w_v_active = (r_v < c_V_W'(V_ACTIVE));

    assign h          = r_h;
    assign active     = (r_h < H_W'(H_ACTIVE)) && w_v_active;
    assign hs_raw     = (r_h >= H_W'(H_ACTIVE + H_FP)) &&
                        (r_h <  H_W'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_raw     = (r_v >= c_V_W'(V_ACTIVE + V_FP)) &&
                        (r_v <  c_V_W'(V_ACTIVE + V_FP + V_SYNC));
    assign line_start = (r_h == '0) && w_v_active;

endmodule
`default_nettype wire

// File: rtl/display_scanout.sv
`default_nettype none
// ============================================================================
// Module   : display_scanout
// Purpose  : Reads lines from two ping-pong line buffers and drives the
//            display with hsync/vsync/de and RGB. Black line plus a sticky
//            flag on buffer underrun; release pulse once a line is consumed.
//   clock, reset      single clock, synchronous active-high reset
//   bus (master)      buffer ready/release, RE/Addr and read data, x2
//   hsync, vsync, de  raster timing, 1 cycle behind the counters
//   pix_r/g/b         pixel, aligned with de
//   underflow         sticky underrun flag
//   clear_underflow   clears underflow (a simultaneous new underrun wins)
// Revision : 1.0 - initial release
// ============================================================================
module display_scanout
    import display_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0
)(
    input  logic              clock,
    input  logic              reset,
    display_scanout_if.master bus,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [PIX_W-1:0]  pix_r,
    output logic [PIX_W-1:0]  pix_g,
    output logic [PIX_W-1:0]  pix_b,
    output logic              underflow,
    input  logic              clear_underflow
);

    localparam int c_H_W = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);

    logic [c_H_W-1:0]  w_h;
    logic              w_active, w_hs_raw, w_vs_raw, w_line_start;

    line_state_t       r_state, w_state_nxt;
    logic              r_sel, w_sel_nxt;
    logic              w_rd_en, w_set_uf, w_h_last;
    logic [1:0]        w_release;
    logic              w_re0, w_re1;
    logic [ADDR_W-1:0] w_addr0, w_addr1, r_addr0, r_addr1;

    logic              r_hsync, r_vsync, r_de, r_rd_vld, r_rd_sel, r_uf;
    rgb_t              w_pix0, w_pix1, w_pix;

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .H_W      (c_H_W)
    ) u_timing (
        .clock      (clock),
        .reset      (reset),
        .h          (w_h),
        .active     (w_active),
        .hs_raw     (w_hs_raw),
        .vs_raw     (w_vs_raw),
        .line_start (w_line_start)
    );

    assign w_h_last = (w_h == c_H_W'(H_ACTIVE - 1));

    // Reads must start in the h==0 cycle so that the data (1 cycle later)
    // lines up with the registered de; the BLANK->SCAN decision therefore
    // also drives the first read directly.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_rd_en     = 1'b0;
        w_release   = 2'b00;
        w_set_uf    = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_BLANK: begin
                    if (w_line_start) begin
                        if (bus.buf_ready[r_sel]) begin
                            w_rd_en     = 1'b1;
                            w_state_nxt = ST_SCAN;
                        end else begin
                            w_set_uf    = 1'b1;
                            w_state_nxt = ST_UNDERRUN;
                        end
                    end
                end
                ST_SCAN: begin
                    w_rd_en = 1'b1;
                    if (w_h_last) w_state_nxt = ST_RELEASE;
                end
                ST_RELEASE: begin
                    w_release[r_sel] = 1'b1;
                    w_sel_nxt        = ~r_sel;
                    w_state_nxt      = ST_BLANK;
                end
                ST_UNDERRUN: begin
                    if (w_h_last) w_state_nxt = ST_BLANK;
                end
                default: w_state_nxt = ST_BLANK;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_BLANK;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    // The idle buffer's address holds its last driven value
    assign w_re0   = w_rd_en & ~r_sel;
    assign w_re1   = w_rd_en &  r_sel;
    assign w_addr0 = w_re0 ? ADDR_W'(w_h) : r_addr0;
    assign w_addr1 = w_re1 ? ADDR_W'(w_h) : r_addr1;

    assign bus.RE0         = w_re0;
    assign bus.RE1         = w_re1;
    assign bus.Addr0       = w_addr0;
    assign bus.Addr1       = w_addr1;
    assign bus.buf_release = w_release;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr0  <= '0;
            r_addr1  <= '0;
            r_hsync  <= ~SYNC_POL;
            r_vsync  <= ~SYNC_POL;
            r_de     <= 1'b0;
            r_rd_vld <= 1'b0;
            r_rd_sel <= 1'b0;
            r_uf     <= 1'b0;
        end else begin
            r_addr0  <= w_addr0;
            r_addr1  <= w_addr1;
            r_hsync  <= w_hs_raw ? SYNC_POL : ~SYNC_POL;
            r_vsync  <= w_vs_raw ? SYNC_POL : ~SYNC_POL;
            r_de     <= w_active;
            r_rd_vld <= w_rd_en;
            r_rd_sel <= r_sel;
            if (w_set_uf)             r_uf <= 1'b1;
            else if (clear_underflow) r_uf <= 1'b0;
        end
    end

    // The buffer's own read register is the pixel register; only a gate
    // and a 2:1 select sit between it and the pins. No read last cycle
    // (underrun or blanking) gives black.
    assign w_pix0 = '{r: bus.red_pix0, g: bus.green_pix0, b: bus.blue_pix0};
    assign w_pix1 = '{r: bus.red_pix1, g: bus.green_pix1, b: bus.blue_pix1};

    always_comb begin
        w_pix = '0;
        if (r_de && r_rd_vld) w_pix = r_rd_sel ? w_pix1 : w_pix0;
    end

    assign hsync     = r_hsync;
    assign vsync     = r_vsync;
    assign de        = r_de;
    assign pix_r     = w_pix.r;
    assign pix_g     = w_pix.g;
    assign pix_b     = w_pix.b;
    assign underflow = r_uf;

endmodule
`default_nettype wire

// File: tb/tb_display_scanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scanout
// Purpose  : Self-checking bench for display_scanout. Two behavioural line
//            buffers with random contents; a line-level reference model
//            derives every expected output from the cycle count since reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_scanout;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [1:0] rdy;

    logic       hsync, vsync, de, underflow;
    logic [7:0] pix_r, pix_g, pix_b;

    always #5 clk = ~clk;

    display_scanout_if bus ();

    display_scanout dut (
        .clock           (clk),
        .reset           (rst),
        .bus             (bus),
        .hsync           (hsync),
        .vsync           (vsync),
        .de              (de),
        .pix_r           (pix_r),
        .pix_g           (pix_g),
        .pix_b           (pix_b),
        .underflow       (underflow),
        .clear_underflow (clr)
    );

    // Line buffer models: synchronous read, data one cycle after RE
    logic [23:0] mem [2][100];
    logic [23:0] q0 = '0;
    logic [23:0] q1 = '0;

    always @(posedge clk) begin
        if (bus.RE0) q0 <= mem[0][bus.Addr0];
        if (bus.RE1) q1 <= mem[1][bus.Addr1];
    end

    assign bus.buf_ready  = rdy;
    assign bus.red_pix0   = q0[23:16];
    assign bus.green_pix0 = q0[15:8];
    assign bus.blue_pix0  = q0[7:0];
    assign bus.red_pix1   = q1[23:16];
    assign bus.green_pix1 = q1[15:8];
    assign bus.blue_pix1  = q1[7:0];

    // Reference model state
    int          m_t;
    int          m_sel, m_mode, m_buf;   // mode: 0 none, 1 scan, 2 underrun
    logic        m_uf;
    int          m_last_addr [2];
    bit          m_prev_rd;
    logic [23:0] m_prev_data;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int b, input bit ramp);
        for (int i = 0; i < 100; i++)
            mem[b][i] = ramp ? {3{8'(i)}} : 24'($urandom);
    endtask

    task automatic model_reset();
        m_t = 0; m_sel = 0; m_mode = 0; m_buf = 0; m_uf = 1'b0;
        m_last_addr[0] = 0; m_last_addr[1] = 0;
        m_prev_rd = 1'b0; m_prev_data = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; clr = 1'b0;
        @(posedge clk); #1;
        chk("rst_re0",   bus.RE0, 0);
        chk("rst_re1",   bus.RE1, 0);
        chk("rst_addr0", bus.Addr0, 0);
        chk("rst_addr1", bus.Addr1, 0);
        chk("rst_rel",   bus.buf_release, 0);
        chk("rst_de",    de, 0);
        chk("rst_pix",   {pix_r, pix_g, pix_b}, 0);
        chk("rst_uf",    underflow, 0);
        chk("rst_hs",    hsync, 1);
        chk("rst_vs",    vsync, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Check one cycle against the model, then advance to the next cycle
    task automatic cycle();
        int h, v, hp, vp;
        bit de_e, hs_e, vs_e, re_e;
        logic [1:0]  rel_e;
        logic [23:0] pix_e;
        #2;
        h  = m_t % 120;
        v  = (m_t / 120) % 108;
        hp = (m_t > 0) ? (m_t - 1) % 120 : 0;
        vp = (m_t > 0) ? ((m_t - 1) / 120) % 108 : 0;
        if (h == 0) begin
            if (v < 100) begin
                m_buf  = m_sel;
                m_mode = rdy[m_sel] ? 1 : 2;
            end else begin
                m_mode = 0;
            end
        end
        re_e  = (m_mode == 1) && (h < 100);
        rel_e = (m_mode == 1 && h == 100) ? 2'(1 << m_buf) : 2'b00;
        de_e  = (m_t > 0) && (hp < 100) && (vp < 100);
        hs_e  = (m_t > 0) && (hp >= 104) && (hp < 112);
        vs_e  = (m_t > 0) && (vp >= 102) && (vp < 104);
        pix_e = (de_e && m_prev_rd) ? m_prev_data : 24'h0;

        chk("re0",       bus.RE0, re_e && m_buf == 0);
        chk("re1",       bus.RE1, re_e && m_buf == 1);
        chk("addr0",     bus.Addr0, (re_e && m_buf == 0) ? h : m_last_addr[0]);
        chk("addr1",     bus.Addr1, (re_e && m_buf == 1) ? h : m_last_addr[1]);
        chk("release",   bus.buf_release, rel_e);
        chk("de",        de, de_e);
        chk("hsync",     hsync, !hs_e);
        chk("vsync",     vsync, !vs_e);
        chk("pix",       {pix_r, pix_g, pix_b}, pix_e);
        chk("underflow", underflow, m_uf);

        m_prev_rd = re_e;
        if (re_e) begin
            m_prev_data          = mem[m_buf][h];
            m_last_addr[m_buf]   = h;
        end
        if (h == 0 && m_mode == 2) m_uf = 1'b1;
        else if (clr)              m_uf = 1'b0;
        if (rel_e != 2'b00) begin
            m_sel = 1 - m_sel;
            fill(m_buf, 1'b0);   // writer refills the released line
        end
        @(posedge clk); #1;
        m_t++;
    endtask

    task automatic run_lines(input int n);
        repeat (n * 120) cycle();
    endtask

    task automatic run_to_h(input int target);
        while (m_t % 120 != target) cycle();
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; rdy = 2'b00;
        fill(0, 1'b0); fill(1, 1'b0);
        model_reset();

        // Full frame with no buffer ready: black active lines, sticky flag
        do_reset();
        run_lines(108);
        chk("s1_uf", underflow, 1);

        // Both ready, buffer 0 holds data = address
        rdy = 2'b11;
        fill(0, 1'b1);
        run_lines(4);

        // Only buffer 0 ready: second line underruns, then buffer 1 comes up
        do_reset();
        rdy = 2'b01;
        run_lines(1);
        run_to_h(50);
        chk("s3_uf", underflow, 1);
        rdy = 2'b10;
        run_to_h(0);
        run_lines(1);

        // Clear coinciding with a new underrun entry, then a plain clear
        rdy = 2'b00;
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("s4_setwins", underflow, 1);
        run_to_h(50);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("s4_clear", underflow, 0);
        run_to_h(0);
        run_to_h(5);

        // Reset in the middle of a buffer-1 line
        do_reset();
        rdy = 2'b11;
        run_lines(1);
        run_to_h(50);
        chk("s5_pre_re1", bus.RE1, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("s5_re1", bus.RE1, 0);
        chk("s5_de",  de, 0);
        chk("s5_rel", bus.buf_release, 0);
        run_lines(2);

        // buf_ready[0] drops mid-scan: the line still completes and releases
        run_to_h(30);
        rdy = 2'b10;
        run_to_h(0);
        run_lines(1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
